// File: rtl/cancel_req_frontend.sv
// cancel_req_frontend: buffers cancelled-order events in a small coalescing
// FIFO and turns each entry into exactly one cache write request. Balance
// queries become cache reads, taken only once the FIFO has fully drained.
module cancel_req_frontend #(
   parameter int DEPTH   = 4,
   parameter int ID_W    = 5,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ID_W-1:0] in_id,
   input  logic [31:0]     in_amt,
   input  logic            qry_valid,
   output logic            qry_ready,
   input  logic [ID_W-1:0] qry_id,
   output logic            qry_done,
   output logic [31:0]     qry_data,
   output logic            req_valid,
   output logic            req_rw,
   output logic [31:0]     req_rdindex,
   output logic [31:0]     req_wrindex,
   output logic [31:0]     req_data,
   input  logic            res_ready,
   input  logic [31:0]     res_data,
   output logic            err,
   output logic [15:0]     wr_cnt,
   output logic [15:0]     coal_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT) + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t            state_reg, state_next;

   logic [PTR_W-1:0]  head_ptr_reg;
   logic [PTR_W-1:0]  tail_ptr_reg;     // next free slot
   logic [PTR_W-1:0]  last_ptr;         // newest occupied slot
   logic [CNT_W-1:0]  count_reg;
   logic              head_lock_reg;

   logic [ID_W-1:0]   ent_id  [DEPTH];
   logic [31:0]       ent_amt [DEPTH];

   logic              req_valid_reg;
   logic              req_rw_reg;
   logic [31:0]       req_index_reg;
   logic [31:0]       req_data_reg;
   logic [TMO_W-1:0]  tmo_reg;
   logic              qry_done_reg;
   logic [31:0]       qry_data_reg;
   logic              err_reg;
   logic [15:0]       wr_cnt_reg;
   logic [15:0]       coal_cnt_reg;

   logic              push;
   logic              tail_frozen;
   logic              coalesce;
   logic              append;
   logic              pop;
   logic              start_wr;
   logic              start_rd;
   logic              done_ok;
   logic              done_tmo;

   // Cache line address of a client: id placed above a 16-byte line offset.
   function automatic logic [31:0] line_index(input logic [ID_W-1:0] id);
      return {{(28-ID_W){1'b0}}, id, 4'b0000};
   endfunction

   assign in_ready  = !rst && (count_reg < CNT_FULL);
   assign qry_ready = !rst && (state_reg == ST_IDLE) && (count_reg == '0);

   assign last_ptr  = tail_ptr_reg - PTR_ONE;
   assign push      = in_valid && in_ready;

   // A lone entry that is being issued on this edge, or already issued, must
   // not absorb more amount: the request registers already hold its total.
   assign tail_frozen = (count_reg == CNT_ONE) &&
                        (head_lock_reg || (state_reg == ST_IDLE));
   assign coalesce    = push && (count_reg != '0) &&
                        (ent_id[last_ptr] == in_id) && !tail_frozen;
   assign append      = push && !coalesce;
   assign pop         = (done_ok || done_tmo) && req_rw_reg;

   // FIFO storage: each slot either takes a fresh event or accumulates into itself.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [ID_W-1:0] id_reg;
         logic [31:0]     amt_reg;

         // Slot write: new entry on append, running sum on coalesce.
         always_ff @(posedge clk) begin
            if (append && (tail_ptr_reg == PTR_W'(gi))) begin
               id_reg  <= in_id;
               amt_reg <= in_amt;
            end else if (coalesce && (last_ptr == PTR_W'(gi))) begin
               amt_reg <= amt_reg + in_amt;
            end
         end

         assign ent_id[gi]  = id_reg;
         assign ent_amt[gi] = amt_reg;
      end
   endgenerate

   // Issue FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Issue FSM next state: pending writes beat queries; GAP drops valid for one cycle.
   always_comb begin
      state_next = state_reg;
      start_wr   = 1'b0;
      start_rd   = 1'b0;
      done_ok    = 1'b0;
      done_tmo   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (count_reg != '0) begin
               start_wr   = 1'b1;
               state_next = ST_ISSUE;
            end else if (qry_valid) begin
               start_rd   = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (res_ready) begin
               done_ok    = 1'b1;
               state_next = ST_GAP;
            end else if (tmo_reg == TMO_LAST) begin
               done_tmo   = 1'b1;
               state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // FIFO pointers, occupancy and head lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_ptr_reg  <= '0;
         tail_ptr_reg  <= '0;
         count_reg     <= '0;
         head_lock_reg <= 1'b0;
      end else begin
         if (append) begin
            tail_ptr_reg <= tail_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            head_ptr_reg <= head_ptr_reg + PTR_ONE;
         end
         case ({append, pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
         if (start_wr) begin
            head_lock_reg <= 1'b1;
         end else if (pop) begin
            head_lock_reg <= 1'b0;
         end
      end
   end

   // Request registers, timeout counter, query result and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_valid_reg <= 1'b0;
         req_rw_reg    <= 1'b0;
         req_index_reg <= '0;
         req_data_reg  <= '0;
         tmo_reg       <= '0;
         qry_done_reg  <= 1'b0;
         qry_data_reg  <= '0;
         err_reg       <= 1'b0;
         wr_cnt_reg    <= '0;
         coal_cnt_reg  <= '0;
      end else begin
         qry_done_reg <= 1'b0;
         if (start_wr) begin
            req_valid_reg <= 1'b1;
            req_rw_reg    <= 1'b1;
            req_index_reg <= line_index(ent_id[head_ptr_reg]);
            req_data_reg  <= ent_amt[head_ptr_reg];
            tmo_reg       <= '0;
         end else if (start_rd) begin
            req_valid_reg <= 1'b1;
            req_rw_reg    <= 1'b0;
            req_index_reg <= line_index(qry_id);
            req_data_reg  <= '0;
            tmo_reg       <= '0;
         end else if (done_ok || done_tmo) begin
            req_valid_reg <= 1'b0;
            if (!req_rw_reg) begin
               qry_done_reg <= 1'b1;
               qry_data_reg <= done_ok ? res_data : 32'd0;
            end
            if (req_rw_reg && done_ok) begin
               wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end
            if (done_tmo) begin
               err_reg <= 1'b1;
            end
         end else if (state_reg == ST_ISSUE) begin
            tmo_reg <= tmo_reg + TMO_ONE;
         end
         if (coalesce) begin
            coal_cnt_reg <= coal_cnt_reg + 16'd1;
         end
      end
   end

   assign req_valid   = req_valid_reg;
   assign req_rw      = req_rw_reg;
   assign req_rdindex = req_index_reg;
   assign req_wrindex = req_index_reg;
   assign req_data    = req_data_reg;
   assign qry_done    = qry_done_reg;
   assign qry_data    = qry_data_reg;
   assign err         = err_reg;
   assign wr_cnt      = wr_cnt_reg;
   assign coal_cnt    = coal_cnt_reg;

endmodule

// File: tb/tb_cancel_req_frontend.sv
// Testbench for cancel_req_frontend: queue-level reference model checked every
// cycle, a small cache responder, and directed scenarios with literal checks.
module tb_cancel_req_frontend;

   localparam int DEPTH   = 4;
   localparam int ID_W    = 5;
   localparam int TIMEOUT = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [ID_W-1:0] in_id;
   logic [31:0]     in_amt;
   logic            qry_valid;
   logic            qry_ready;
   logic [ID_W-1:0] qry_id;
   logic            qry_done;
   logic [31:0]     qry_data;
   logic            req_valid;
   logic            req_rw;
   logic [31:0]     req_rdindex;
   logic [31:0]     req_wrindex;
   logic [31:0]     req_data;
   logic            res_ready;
   logic [31:0]     res_data;
   logic            err;
   logic [15:0]     wr_cnt;
   logic [15:0]     coal_cnt;

   always #5 clk = ~clk;

   cancel_req_frontend #(.DEPTH(DEPTH), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_amt(in_amt),
      .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_id(qry_id),
      .qry_done(qry_done), .qry_data(qry_data),
      .req_valid(req_valid), .req_rw(req_rw), .req_rdindex(req_rdindex),
      .req_wrindex(req_wrindex), .req_data(req_data),
      .res_ready(res_ready), .res_data(res_data),
      .err(err), .wr_cnt(wr_cnt), .coal_cnt(coal_cnt)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // ---------------- reference model (queue of pending cancellations) -------
   typedef struct {
      logic [ID_W-1:0] id;
      logic [31:0]     amt;
   } ent_t;

   ent_t            mq[$];
   int              m_ph = 0;          // 0 idle, 1 request outstanding, 2 gap
   int              m_t = 0;           // cycles spent with request outstanding
   logic [ID_W-1:0] m_cur_id = '0;
   logic [31:0]     mbal [32];         // balances the cache must hold

   logic            e_req_valid = 0;
   logic            e_req_rw = 0;
   logic [31:0]     e_req_index = 0;
   logic [31:0]     e_req_data = 0;
   logic            e_qry_done = 0;
   logic [31:0]     e_qry_data = 0;
   logic            e_err = 0;
   logic [15:0]     e_wr_cnt = 0;
   logic [15:0]     e_coal_cnt = 0;

   // ---------------- cache responder ---------------------------------------
   logic [31:0]     rbal [32];
   bit              resp_on = 0;
   int              resp_delay = 0;
   int              vcnt = 0;
   bit              pend_wr = 0;
   logic [ID_W-1:0] pend_id = '0;
   logic [31:0]     pend_data = '0;
   int              wr_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs presented to the DUT.
   task automatic mdl_step();
      bit   accept, issue_now, locked, coal, pop;
      ent_t e;
      if (rst) begin
         mq.delete();
         m_ph = 0; m_t = 0;
         e_req_valid = 0; e_req_rw = 0; e_req_index = 0; e_req_data = 0;
         e_qry_done = 0; e_qry_data = 0; e_err = 0; e_wr_cnt = 0; e_coal_cnt = 0;
         return;
      end
      e_qry_done = 0;
      pop        = 0;
      accept     = in_valid && (mq.size() < DEPTH);
      issue_now  = (m_ph == 0) && (mq.size() > 0);
      locked     = (m_ph == 1) && e_req_rw;
      coal       = accept && (mq.size() > 0) && (mq[mq.size()-1].id == in_id) &&
                   !((mq.size() == 1) && (locked || issue_now));
      case (m_ph)
         0: begin
            if (mq.size() > 0) begin
               e_req_valid = 1; e_req_rw = 1;
               e_req_index = 32'(mq[0].id) << 4; e_req_data = mq[0].amt;
               m_ph = 1; m_t = 0;
            end else if (qry_valid) begin
               e_req_valid = 1; e_req_rw = 0;
               e_req_index = 32'(qry_id) << 4; e_req_data = 0;
               m_cur_id = qry_id;
               m_ph = 1; m_t = 0;
            end
         end
         1: begin
            if (res_ready) begin
               if (e_req_rw) begin
                  mbal[mq[0].id] += mq[0].amt;
                  e_wr_cnt++;
                  pop = 1;
               end else begin
                  e_qry_done = 1;
                  e_qry_data = mbal[m_cur_id];
               end
               e_req_valid = 0; m_ph = 2;
            end else if (m_t == TIMEOUT - 1) begin
               e_err = 1;
               if (e_req_rw) pop = 1;
               else begin
                  e_qry_done = 1;
                  e_qry_data = 0;
               end
               e_req_valid = 0; m_ph = 2;
            end else begin
               m_t++;
            end
         end
         default: m_ph = 0;
      endcase
      if (pop) void'(mq.pop_front());
      if (accept) begin
         if (coal) begin
            e = mq[mq.size()-1];
            e.amt += in_amt;
            mq[mq.size()-1] = e;
            e_coal_cnt++;
         end else begin
            e.id = in_id; e.amt = in_amt;
            mq.push_back(e);
         end
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   task automatic check_outputs();
      chk("in_ready",    in_ready,    32'(!rst && (mq.size() < DEPTH)));
      chk("qry_ready",   qry_ready,   32'(!rst && (m_ph == 0) && (mq.size() == 0)));
      chk("req_valid",   req_valid,   e_req_valid);
      chk("req_rw",      req_rw,      e_req_rw);
      chk("req_rdindex", req_rdindex, e_req_index);
      chk("req_wrindex", req_wrindex, e_req_index);
      chk("req_data",    req_data,    e_req_data);
      chk("qry_done",    qry_done,    e_qry_done);
      chk("qry_data",    qry_data,    e_qry_data);
      chk("err",         err,         e_err);
      chk("wr_cnt",      wr_cnt,      e_wr_cnt);
      chk("coal_cnt",    coal_cnt,    e_coal_cnt);
   endtask

   // Cache responder: raise res_ready once valid has been seen resp_delay cycles.
   task automatic resp_eval();
      res_ready = resp_on && req_valid && (vcnt >= resp_delay);
      res_data  = rbal[req_rdindex[4 +: ID_W]];
      pend_wr   = res_ready && req_rw;
      pend_id   = req_wrindex[4 +: ID_W];
      pend_data = req_data;
   endtask

   task automatic tick();
      @(posedge clk);
      mdl_step();
      if (pend_wr && !rst) begin
         rbal[pend_id] += pend_data;
         wr_log.push_back(int'(pend_id));
      end
      pend_wr = 0;
      @(negedge clk);
      check_outputs();
      vcnt = req_valid ? vcnt + 1 : 0;
      resp_eval();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int   bursts, vc, ndone, wr_before;
      bit   rd_seen, seen5;
      logic prev;

      for (int i = 0; i < 32; i++) begin
         mbal[i] = 0;
         rbal[i] = 0;
      end
      rst = 1; in_valid = 0; in_id = '0; in_amt = '0;
      qry_valid = 0; qry_id = '0; res_ready = 0; res_data = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_req_valid", req_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_qry_ready", qry_ready, 0);
      chk("rst_wr_cnt", wr_cnt, 0);
      rst = 0;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_qry_ready", qry_ready, 1);
      $display("txn reset: in_ready=%0b qry_ready=%0b", in_ready, qry_ready);

      // T1: single write, responder answers on the 4th valid cycle
      resp_on = 1; resp_delay = 4;
      in_valid = 1; in_id = 5'd3; in_amt = 32'h10;
      tick();
      in_valid = 0;
      bursts = 0; vc = 0; prev = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (req_valid) begin
            vc++;
            chk("t1_wrindex", req_wrindex, 32'h30);
            chk("t1_data", req_data, 32'h10);
         end
         if (req_valid && !prev) bursts++;
         if (prev && !req_valid) chk("t1_gap_wr_cnt", wr_cnt, 1);
         prev = req_valid;
      end
      chk("t1_bursts", bursts, 1);
      chk("t1_valid_cycles", vc, 4);
      chk("t1_wr_cnt", wr_cnt, 1);
      $display("txn T1 write id=3: bursts=%0d valid_cycles=%0d wr_cnt=%0d", bursts, vc, wr_cnt);

      // T2: coalescing behind a stalled head
      resp_on = 0;
      in_valid = 1; in_id = 5'd2; in_amt = 32'h7;
      tick();
      in_valid = 0;
      tick();
      chk("t2_head_valid", req_valid, 1);
      chk("t2_head_index", req_wrindex, 32'h20);
      in_valid = 1; in_id = 5'd5;
      for (int a = 1; a <= 3; a++) begin
         in_amt = 32'(a);
         tick();
      end
      in_valid = 0;
      chk("t2_coal_cnt", coal_cnt, 2);
      resp_on = 1; resp_delay = 1;
      resp_eval();
      seen5 = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (req_valid && req_wrindex == 32'h50) begin
            seen5 = 1;
            chk("t2_coalesced_data", req_data, 32'h6);
         end
      end
      chk("t2_seen_id5", seen5, 1);
      chk("t2_wr_cnt", wr_cnt, 3);
      $display("txn T2 coalesce id=5: coal_cnt=%0d wr_cnt=%0d", coal_cnt, wr_cnt);

      // T3: fill to DEPTH with no response, head times out
      resp_on = 0;
      resp_eval();
      vc = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_id = 5'(10 + i); in_amt = 32'(32'h100 + i);
         tick();
         if (req_valid) vc++;
      end
      in_id = 5'd14; in_amt = 32'h200;
      chk("t3_full_in_ready", in_ready, 0);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (err) break;
         if (req_valid) vc++;
      end
      chk("t3_issue_cycles", vc, TIMEOUT);
      chk("t3_err", err, 1);
      chk("t3_in_ready_back", in_ready, 1);
      chk("t3_wr_cnt_unchanged", wr_cnt, 3);
      tick();
      in_valid = 0;
      resp_on = 1; resp_delay = 2;
      resp_eval();
      repeat (40) tick();
      chk("t3_wr_cnt_drained", wr_cnt, 7);
      chk("t3_err_sticky", err, 1);
      $display("txn T3 timeout: issue_cycles=%0d err=%0b wr_cnt=%0d", vc, err, wr_cnt);

      // T4: query for id=3 waits behind two pending writes
      in_valid = 1; in_id = 5'd3; in_amt = 32'h5;
      tick();
      wr_before = int'(wr_cnt);
      qry_valid = 1; qry_id = 5'd3;
      in_id = 5'd4; in_amt = 32'h9;
      tick();
      in_valid = 0;
      rd_seen = 0; ndone = 0;
      for (int i = 0; i < 40; i++) begin
         bit acc;
         acc = qry_valid && qry_ready;
         tick();
         if (acc) qry_valid = 0;
         if (req_valid && !req_rw && !rd_seen) begin
            rd_seen = 1;
            chk("t4_writes_first", int'(wr_cnt) - wr_before, 2);
            chk("t4_rdindex", req_rdindex, 32'h30);
         end
         if (qry_done) begin
            ndone++;
            chk("t4_qry_data", qry_data, 32'h15);
         end
      end
      chk("t4_read_seen", rd_seen, 1);
      chk("t4_done_pulses", ndone, 1);
      $display("txn T4 query id=3: data=0x%0h pulses=%0d", qry_data, ndone);

      // T5: reset while a write is in flight with 3 entries queued
      resp_on = 0;
      resp_eval();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_id = 5'(20 + i); in_amt = 32'(i + 1);
         tick();
      end
      in_valid = 0;
      chk("t5_valid_before", req_valid, 1);
      rst = 1;
      tick();
      chk("t5_rst_valid", req_valid, 0);
      rst = 0;
      tick();
      chk("t5_empty_in_ready", in_ready, 1);
      chk("t5_empty_qry_ready", qry_ready, 1);
      chk("t5_wr_cnt_cleared", wr_cnt, 0);
      resp_on = 1; resp_delay = 0;
      bursts = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (req_valid) bursts++;
      end
      chk("t5_no_stale_req", bursts, 0);
      $display("txn T5 reset mid-issue: stale_valid_cycles=%0d", bursts);

      // T6: simultaneous push and pop at DEPTH-1 across pointer wrap
      in_valid = 1; in_id = 5'd24; in_amt = 32'h1;
      tick();
      in_valid = 0;
      repeat (8) tick();
      wr_log.delete();
      resp_on = 0;
      resp_eval();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_id = 5'(25 + i); in_amt = 32'(32'h25 + i);
         tick();
      end
      in_valid = 0;
      tick();
      in_valid = 1; in_id = 5'd28; in_amt = 32'h28;
      resp_on = 1; resp_delay = 0;
      resp_eval();
      chk("t6_res_ready_armed", res_ready, 1);
      tick();
      chk("t6_in_ready_dm1", in_ready, 1);
      in_id = 5'd29; in_amt = 32'h29;
      tick();
      chk("t6_full_after_push", in_ready, 0);
      in_valid = 0;
      repeat (30) tick();
      chk("t6_log_size", wr_log.size(), 5);
      for (int i = 0; i < 5; i++) begin
         int got;
         got = (i < wr_log.size()) ? wr_log[i] : -1;
         chk("t6_order", got, 25 + i);
      end
      chk("t6_wr_cnt", wr_cnt, 6);
      $display("txn T6 push+pop wrap: writes=%0d wr_cnt=%0d", wr_log.size(), wr_cnt);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cancel_req_frontend.md
# cancel_req_frontend

Upstream feeder for the downstream cancel-accumulation cache FSM. It accepts a stream of cancelled-order events (client ID, amount), buffers them in a small coalescing FIFO, and issues one CPU-side write request per entry to the cache. The cache adds each request's data into the client's line. The block also serves balance queries as cache reads, and guarantees that no request is issued twice and that every accepted cancellation is reflected before a query is answered.

## Interface
- DEPTH, 4: FIFO entries, power of two, at least 2.
- ID_W, 5: client ID width.
- TIMEOUT, 16: maximum cycles spent in ISSUE before the request is abandoned.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  cancellation event valid.
- in_ready  out  1  event accepted when in_valid && in_ready.
- in_id  in  ID_W  client ID.
- in_amt  in  32  cancelled amount.
- qry_valid / qry_ready  in / out  1  balance-query handshake.
- qry_id  in  ID_W  client to read.
- qry_done  out  1  one-cycle pulse; qry_data is valid.
- qry_data  out  32  balance returned by the cache.
- req_valid, req_rw  out  1  map to cpu_req.valid and cpu_req.rw.
- req_rdindex, req_wrindex  out  32  map to cpu_req.rdindex and cpu_req.wrindex; value is {zero, id, 4'b0000}.
- req_data  out  32  maps to cpu_req.data.
- res_ready  in  1  cpu_res.ready.
- res_data  in  32  cpu_res.data.
- err  out  1  sticky timeout flag.
- wr_cnt  out  16  completed writes, wraps.
- coal_cnt  out  16  coalesced events, wraps.

## Operation
- FIFO entries hold {id, amt}. The head entry is "locked" once it has been issued.
- Push rules:
  - in_ready = !rst && count < DEPTH.
  - On an accepted event, coalesce if count > 0, the tail id equals in_id, and the tail is not locked. Coalescing means tail.amt += in_amt (mod 2^32), count is unchanged, and coal_cnt increments.
  - Otherwise append a new entry.
  - Coalescing is allowed even when the FIFO is full, but in_ready is still 0 when full, so it never actually happens at full.
- Issue FSM, states IDLE, ISSUE, GAP:
  - IDLE → ISSUE when count > 0. Load the head into the request registers with req_rw=1 and lock the head.
  - IDLE → ISSUE with req_rw=0 when count == 0 and qry_valid. In this state qry_ready = 1, and the query is accepted on that edge.
  - When both are possible, writes always have priority. A query is only taken with the FIFO empty, so it observes every earlier accepted event.
  - ISSUE: req_valid=1 and all req_* fields are held stable. When res_ready is sampled high, go to GAP.
    - For a write: pop the head and increment wr_cnt.
    - For a read: capture res_data into qry_data and pulse qry_done in the next cycle.
  - ISSUE with the timeout counter at TIMEOUT-1 and res_ready still low: go to GAP and set err.
    - For a write: pop the entry (dropped).
    - For a read: qry_done pulses with qry_data=0.
  - GAP: req_valid=0 for exactly one cycle, then IDLE. GAP exists so the cache, which has returned to idle, never sees a stale valid. A repeated valid would double-accumulate.
- A simultaneous push and pop in the same cycle is legal. count is unchanged and the newly pushed entry is unlocked.

## Timing
- Reset values: req_valid=0, req_rw=0, req indexes and req_data=0, qry_done=0, qry_data=0, err=0, wr_cnt=0, coal_cnt=0, FIFO empty, state IDLE, in_ready=0 and qry_ready=0 while rst is high.
- rst asserted mid-operation: the FIFO contents and any in-flight request are discarded, and req_valid is 0 the following cycle.
- Request timing:
  - req_valid rises in the cycle after the IDLE edge: one cycle from push to issue on an empty FIFO.
  - Minimum write occupancy: ISSUE ≥1 cycle plus GAP 1 cycle plus IDLE 1 cycle, i.e. one write per 3 cycles at best.
- Query timing: qry_done rises in the cycle after the res_ready edge.
- The timeout counter counts cycles in ISSUE starting at 0. Abandonment occurs on the TIMEOUT-th cycle.
- req_* outputs come from registers. in_ready and qry_ready are combinational from state and count only.

## Test plan
- Reset, then push {id=3, amt=0x10}, with the model responding res_ready after 4 cycles → exactly one req_valid burst with wrindex=0x30 and data=0x10. Then wr_cnt=1 and req_valid is low in the GAP cycle.
- Push id=5 with amt 1, 2, 3 on consecutive cycles while the head (id=2) is stalled in ISSUE → one entry {5, 6}, coal_cnt=2, and total writes = 2.
- Fill to DEPTH with distinct ids and hold res_ready=0 → in_ready=0. After TIMEOUT cycles, err=1, the head is dropped, and in_ready returns to 1.
- Assert qry_valid for id=3 with 2 writes pending → both writes are issued first. The read has rw=0 and rdindex=0x30, and qry_data equals the model's res_data with qry_done pulsing once.
- Assert rst while in ISSUE with 3 entries queued → the next cycle shows req_valid=0 and count=0. After deassertion, no stale request is issued.
- Push and pop in the same cycle at count=DEPTH-1 → count stays DEPTH-1 and FIFO order is preserved across pointer wrap.
